hour_counter_ampm: RTL and testbench

//  Parametrised BCD hour counter with a selectable 12/24-hour display mode and an AM/PM flag.

---
 rtl/hour_counter_ampm_if.sv | 28 ++
 rtl/hour_counter_ampm.sv | 107 ++++++++++
 tb/tb_hour_counter_ampm.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hour_counter_ampm_if.sv
// Control/display bundle between the hour counter and its set buttons,
// minute stage, calendar stage and display mux.
interface hour_counter_ampm_if;
  logic       inc;
  logic       adj_up;
  logic       adj_dn;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_units;
  logic       load_am;
  logic       mode_24h;
  logic [3:0] hour_tens;
  logic [3:0] hour_units;
  logic       am;
  logic       day_carry;
  logic       noon;
  logic       load_err;

  modport master (
    output inc, adj_up, adj_dn, load, load_tens, load_units, load_am, mode_24h,
    input  hour_tens, hour_units, am, day_carry, noon, load_err
  );

  modport slave (
    input  inc, adj_up, adj_dn, load, load_tens, load_units, load_am, mode_24h,
    output hour_tens, hour_units, am, day_carry, noon, load_err
  );
endinterface

// File: rtl/hour_counter_ampm.sv
// Binary 0..23 hour register with BCD 12h/24h display decode, AM flag,
// prioritised load/adjust/increment and registered one-cycle event pulses.
module hour_counter_ampm #(
  parameter int RESET_HOUR = 0,
  parameter bit ADJ_WRAP   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  hour_counter_ampm_if.slave  bus
);

  localparam logic [4:0] RST_H = 5'(RESET_HOUR);

  logic [4:0] h24, h24_nxt;
  logic       day_carry_q, noon_q, load_err_q;
  logic       day_carry_nxt, noon_nxt, load_err_nxt;

  logic [7:0] ld_v;
  logic       ld_ok;
  logic [4:0] ld_h;

  // Load value decode; 12h AM/PM folds into the 0..23 range here.
  always_comb begin
    ld_v  = 8'(bus.load_tens) * 8'd10 + 8'(bus.load_units);
    ld_ok = 1'b0;
    ld_h  = 5'(ld_v);
    if (bus.load_units <= 4'd9 && bus.load_tens <= 4'd2) begin
      if (bus.mode_24h) begin
        ld_ok = (ld_v <= 8'd23);
      end else begin
        ld_ok = (ld_v >= 8'd1) && (ld_v <= 8'd12);
        if (bus.load_am) ld_h = (ld_v == 8'd12) ? 5'd0 : 5'(ld_v);
        else             ld_h = (ld_v == 8'd12) ? 5'd12 : 5'(ld_v) + 5'd12;
      end
    end
  end

  // Exactly one action per edge: load > adj_up > adj_dn > inc.
  always_comb begin
    h24_nxt       = h24;
    day_carry_nxt = 1'b0;
    noon_nxt      = 1'b0;
    load_err_nxt  = 1'b0;
    if (bus.load) begin
      if (ld_ok) h24_nxt = ld_h;
      else       load_err_nxt = 1'b1;
    end else if (bus.adj_up) begin
      if (h24 == 5'd23) h24_nxt = ADJ_WRAP ? 5'd0 : 5'd23;
      else              h24_nxt = h24 + 5'd1;
    end else if (bus.adj_dn) begin
      if (h24 == 5'd0) h24_nxt = ADJ_WRAP ? 5'd23 : 5'd0;
      else             h24_nxt = h24 - 5'd1;
    end else if (bus.inc) begin
      if (h24 == 5'd23) begin
        h24_nxt       = 5'd0;
        day_carry_nxt = 1'b1;
      end else begin
        h24_nxt  = h24 + 5'd1;
        noon_nxt = (h24 == 5'd11);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h24         <= RST_H;
      day_carry_q <= 1'b0;
      noon_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      h24         <= h24_nxt;
      day_carry_q <= day_carry_nxt;
      noon_q      <= noon_nxt;
      load_err_q  <= load_err_nxt;
    end
  end

  logic [4:0] disp;
  logic [3:0] tens, units;

  // 12h shows 12 for hours 0 and 12, otherwise folds 13..23 down to 1..11.
  always_comb begin
    disp = h24;
    if (!bus.mode_24h) begin
      if (h24 == 5'd0)      disp = 5'd12;
      else if (h24 > 5'd12) disp = h24 - 5'd12;
    end
    if (disp >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(disp - 5'd20);
    end else if (disp >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(disp - 5'd10);
    end else begin
      tens  = 4'd0;
      units = 4'(disp);
    end
  end

  assign bus.hour_tens  = tens;
  assign bus.hour_units = units;
  assign bus.am         = (h24 < 5'd12);
  assign bus.day_carry  = day_carry_q;
  assign bus.noon       = noon_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_hour_counter_ampm.sv
// Scoreboard bench: expected display/pulse words are queued as stimulus is
// applied, observed words queued after each edge, and each task drains both.
module tb_hour_counter_ampm;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hour_counter_ampm_if if1 ();
  hour_counter_ampm_if if2 ();

  hour_counter_ampm #(.RESET_HOUR(0), .ADJ_WRAP(1'b1)) dut (.clk(clk), .rst(rst), .bus(if1));
  hour_counter_ampm #(.RESET_HOUR(5), .ADJ_WRAP(1'b0)) dut_sat (.clk(clk), .rst(rst), .bus(if2));

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
    logic       am;
    logic       dc;
    logic       noon;
    logic       le;
  } obs_t;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic obs_t mk(int t, int u, bit a, bit dc = 0, bit n = 0, bit le = 0);
    mk = {4'(t), 4'(u), a, dc, n, le};
  endfunction

  task automatic sample();
    got_q.push_back({if1.hour_tens, if1.hour_units, if1.am, if1.day_carry, if1.noon, if1.load_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    {if1.inc, if1.adj_up, if1.adj_dn, if1.load} = '0;
    {if2.inc, if2.adj_up, if2.adj_dn, if2.load} = '0;
  endtask

  task automatic stepc();
    tick();
    sample();
  endtask

  task automatic ld(int t, int u, bit a = 1'b0);
    if1.load = 1'b1; if1.load_tens = 4'(t); if1.load_units = 4'(u); if1.load_am = a;
  endtask

  task automatic test_reset();
    obs_t e, g;
    #1 rst = 1'b1;
    #1 sample(); exp_q.push_back(mk(1, 2, 1));
    n_cmp++;
    if ({if2.hour_tens, if2.hour_units, if2.am} !== {4'd0, 4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_hour5: got %0d%0d am=%0b expected 05 am=1", if2.hour_tens, if2.hour_units, if2.am);
    end
    @(negedge clk) rst = 1'b0;
    stepc(); exp_q.push_back(mk(1, 2, 1));
    if1.mode_24h = 1'b1;
    #1 sample(); exp_q.push_back(mk(0, 0, 1));
    stepc(); exp_q.push_back(mk(0, 0, 1));
    if1.mode_24h = 1'b0;
    #1 sample(); exp_q.push_back(mk(1, 2, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL reset #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  task automatic test_inc();
    obs_t e, g;
    if1.mode_24h = 1'b1;
    ld(1, 1); stepc(); exp_q.push_back(mk(1, 1, 1));
    if1.mode_24h = 1'b0;
    #1 sample(); exp_q.push_back(mk(1, 1, 1));
    if1.inc = 1'b1; stepc(); exp_q.push_back(mk(1, 2, 0, 0, 1, 0));
    stepc(); exp_q.push_back(mk(1, 2, 0));
    if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 1, 0));
    if1.mode_24h = 1'b1;
    ld(2, 3); stepc(); exp_q.push_back(mk(2, 3, 0));
    if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 0, 1, 1, 0, 0));
    stepc(); exp_q.push_back(mk(0, 0, 1));
    if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 1, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL inc #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  task automatic test_load();
    obs_t e, g;
    if1.mode_24h = 1'b0;
    ld(1, 2, 0); stepc(); exp_q.push_back(mk(1, 2, 0));
    ld(1, 2, 1); stepc(); exp_q.push_back(mk(1, 2, 1));
    ld(0, 7, 0); stepc(); exp_q.push_back(mk(0, 7, 0));
    if1.mode_24h = 1'b1;
    #1 sample(); exp_q.push_back(mk(1, 9, 0));
    ld(0, 0, 0); stepc(); exp_q.push_back(mk(0, 0, 1));
    ld(1, 2, 1); stepc(); exp_q.push_back(mk(1, 2, 0));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL load #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  task automatic test_load_err();
    obs_t e, g;
    if1.mode_24h = 1'b1;
    ld(0, 9, 1); stepc(); exp_q.push_back(mk(0, 9, 1));
    ld(2, 4, 0); stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    stepc(); exp_q.push_back(mk(0, 9, 1));
    if1.mode_24h = 1'b0;
    ld(0, 0, 1); stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    ld(1, 10, 1); stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    ld(1, 3, 0); stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    ld(3, 0, 0); if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    if1.mode_24h = 1'b1;
    ld(15, 0, 0); if1.adj_up = 1'b1; stepc(); exp_q.push_back(mk(0, 9, 1, 0, 0, 1));
    stepc(); exp_q.push_back(mk(0, 9, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL load_err #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  task automatic test_priority();
    obs_t e, g;
    if1.mode_24h = 1'b1;
    ld(2, 3); stepc(); exp_q.push_back(mk(2, 3, 0));
    if1.adj_up = 1'b1; if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 0, 1));
    if1.adj_dn = 1'b1; if1.inc = 1'b1; stepc(); exp_q.push_back(mk(2, 3, 0));
    if1.adj_up = 1'b1; if1.adj_dn = 1'b1; stepc(); exp_q.push_back(mk(0, 0, 1));
    ld(0, 5); if1.adj_up = 1'b1; if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 5, 1));
    if1.mode_24h = 1'b0;
    ld(1, 1, 1); stepc(); exp_q.push_back(mk(1, 1, 1));
    if1.adj_up = 1'b1; stepc(); exp_q.push_back(mk(1, 2, 0));
    if1.adj_dn = 1'b1; stepc(); exp_q.push_back(mk(1, 1, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL priority #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  task automatic test_saturate();
    if2.mode_24h = 1'b1;
    if2.load = 1'b1; if2.load_tens = 4'd0; if2.load_units = 4'd0; tick();
    if2.adj_dn = 1'b1; tick();
    n_cmp++;
    if ({if2.hour_tens, if2.hour_units, if2.am, if2.day_carry} !== {4'd0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_dn: got %0d%0d am=%0b dc=%0b expected 00 am=1 dc=0", if2.hour_tens, if2.hour_units, if2.am, if2.day_carry);
    end
    if2.load = 1'b1; if2.load_tens = 4'd2; if2.load_units = 4'd3; tick();
    if2.adj_up = 1'b1; tick();
    n_cmp++;
    if ({if2.hour_tens, if2.hour_units, if2.am, if2.day_carry} !== {4'd2, 4'd3, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_up: got %0d%0d am=%0b dc=%0b expected 23 am=0 dc=0", if2.hour_tens, if2.hour_units, if2.am, if2.day_carry);
    end
    if2.inc = 1'b1; tick();
    n_cmp++;
    if ({if2.hour_tens, if2.hour_units, if2.day_carry} !== {4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_inc_wrap: got %0d%0d dc=%0b expected 00 dc=1", if2.hour_tens, if2.hour_units, if2.day_carry);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e, g;
    if1.mode_24h = 1'b1;
    ld(1, 5); stepc(); exp_q.push_back(mk(1, 5, 0));
    #2 rst = 1'b1;
    #1 sample(); exp_q.push_back(mk(0, 0, 1));
    @(negedge clk) rst = 1'b0;
    ld(2, 3); stepc(); exp_q.push_back(mk(2, 3, 0));
    if1.inc = 1'b1; stepc(); exp_q.push_back(mk(0, 0, 1, 1, 0, 0));
    #2 rst = 1'b1;
    #1 sample(); exp_q.push_back(mk(0, 0, 1));
    @(negedge clk) rst = 1'b0;
    stepc(); exp_q.push_back(mk(0, 0, 1));
    ld(2, 4); stepc(); exp_q.push_back(mk(0, 0, 1, 0, 0, 1));
    #2 rst = 1'b1;
    #1 sample(); exp_q.push_back(mk(0, 0, 1));
    @(negedge clk) rst = 1'b0;
    stepc(); exp_q.push_back(mk(0, 0, 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); n_cmp++;
      g = (got_q.size() > 0) ? got_q.pop_front() : 'x;
      if (g !== e) begin n_fail++; $display("FAIL reset_mid #%0d: got %p expected %p", i, g, e); end
    end
  endtask

  initial begin
    {if1.inc, if1.adj_up, if1.adj_dn, if1.load, if1.load_am, if1.mode_24h} = '0;
    {if2.inc, if2.adj_up, if2.adj_dn, if2.load, if2.load_am, if2.mode_24h} = '0;
    if1.load_tens = '0; if1.load_units = '0;
    if2.load_tens = '0; if2.load_units = '0;
    test_reset();
    test_inc();
    test_load();
    test_load_err();
    test_priority();
    test_saturate();
    test_reset_mid();
    if (got_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL leftover_samples: got %0d extra expected 0", got_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
